// File: rtl/tempsensor_i2c_ctrl.sv
// tempsensor_i2c_ctrl: sequences an I2C master to write one sensor config
// byte after reset, then poll the 2-byte temperature register.
// Ports: clk/reset (async, active low); run/poll_now poll control;
// go/rw/N_Byte/dev_add/R_Pointer/dwr_DataWriteReg/Master_Enable drive the
// master; done/ready/ack_e/drd_lcdData come back from it; temp_data,
// temp_valid, nack_err, timeout_err, err_count and busy report status.
module tempsensor_i2c_ctrl #(
  parameter logic [6:0]  DEV_ADDR    = 7'h48,
  parameter logic [7:0]  CFG_PTR     = 8'h01,
  parameter logic [7:0]  CFG_BYTE    = 8'h60,
  parameter logic [7:0]  TEMP_PTR    = 8'h00,
  parameter int unsigned POLL_CYCLES = 50000000,
  parameter int unsigned START_TO    = 16,
  parameter int unsigned XFER_TO     = 1000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic        poll_now,
  output logic        go,
  output logic        rw,
  output logic [5:0]  N_Byte,
  output logic [6:0]  dev_add,
  output logic [7:0]  R_Pointer,
  output logic [7:0]  dwr_DataWriteReg,
  output logic        Master_Enable,
  input  logic        done,
  input  logic        ready,
  input  logic        ack_e,
  input  logic [7:0]  drd_lcdData,
  output logic [15:0] temp_data,
  output logic        temp_valid,
  output logic        nack_err,
  output logic        timeout_err,
  output logic [7:0]  err_count,
  output logic        busy
);

  typedef enum logic [2:0] {
    CFG_ISSUE,
    RD_ISSUE,
    ISSUE_WAIT,
    XFER,
    COMPLETE,
    POLL_WAIT,
    MRESET
  } state_t;

  localparam logic [23:0] POLL_LAST  = 24'(POLL_CYCLES - 1);
  localparam logic [19:0] START_LAST = 20'(START_TO - 1);
  localparam logic [19:0] XFER_LAST  = 20'(XFER_TO - 1);

  state_t      state;
  logic [23:0] poll_cnt;
  logic [19:0] to_cnt;
  logic        mr_cnt;
  logic [1:0]  byte_idx;
  logic        nack_seen;
  logic        poll_pend;
  logic [7:0]  msb_r;
  logic [7:0]  lsb_r;
  logic        ready_q;
  logic        done_q;

  logic        ready_rise;
  logic        done_fall;
  logic        done_rise;
  logic        to_fire;
  logic [7:0]  err_inc;

  assign ready_rise = ready & ~ready_q;
  assign done_fall  = ~done & done_q;
  assign done_rise  = done & ~done_q;

  // One shared watchdog counter; it is cleared on entry to each wait state.
  assign to_fire =
    ((state == ISSUE_WAIT) && !done_fall && (to_cnt == START_LAST)) ||
    ((state == XFER) && !done_rise && (to_cnt == XFER_LAST));

  assign err_inc = (err_count == 8'hFF) ? 8'hFF : err_count + 8'd1;
  assign dev_add = DEV_ADDR;
  assign busy    = (state != POLL_WAIT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state            <= CFG_ISSUE;
      go               <= 1'b0;
      rw               <= 1'b0;
      N_Byte           <= 6'd0;
      R_Pointer        <= 8'd0;
      dwr_DataWriteReg <= 8'd0;
      Master_Enable    <= 1'b1;
      temp_data        <= 16'd0;
      temp_valid       <= 1'b0;
      nack_err         <= 1'b0;
      timeout_err      <= 1'b0;
      err_count        <= 8'd0;
      poll_cnt         <= 24'd0;
      to_cnt           <= 20'd0;
      mr_cnt           <= 1'b0;
      byte_idx         <= 2'd0;
      nack_seen        <= 1'b0;
      poll_pend        <= 1'b0;
      msb_r            <= 8'd0;
      lsb_r            <= 8'd0;
      ready_q          <= 1'b0;
      done_q           <= 1'b1;
    end else begin
      ready_q     <= ready;
      done_q      <= done;
      temp_valid  <= 1'b0;
      nack_err    <= 1'b0;
      timeout_err <= 1'b0;
      if (poll_now) poll_pend <= 1'b1;
      if (to_fire) begin
        go            <= 1'b0;
        Master_Enable <= 1'b0;
        timeout_err   <= 1'b1;
        err_count     <= err_inc;
        mr_cnt        <= 1'b0;
        state         <= MRESET;
      end else begin
        unique case (state)
          CFG_ISSUE: begin
            rw               <= 1'b0;
            N_Byte           <= 6'd1;
            R_Pointer        <= CFG_PTR;
            dwr_DataWriteReg <= CFG_BYTE;
            go               <= 1'b1;
            byte_idx         <= 2'd0;
            nack_seen        <= 1'b0;
            to_cnt           <= 20'd0;
            state            <= ISSUE_WAIT;
          end
          RD_ISSUE: begin
            rw        <= 1'b1;
            N_Byte    <= 6'd2;
            R_Pointer <= TEMP_PTR;
            go        <= 1'b1;
            byte_idx  <= 2'd0;
            nack_seen <= 1'b0;
            to_cnt    <= 20'd0;
            state     <= ISSUE_WAIT;
          end
          ISSUE_WAIT: begin
            if (done_fall) begin
              go     <= 1'b0;
              to_cnt <= 20'd0;
              state  <= XFER;
            end else begin
              to_cnt <= to_cnt + 20'd1;
            end
          end
          XFER: begin
            nack_seen <= nack_seen | ack_e;
            // Write data was latched at issue; only reads capture bytes.
            if (ready_rise && rw) begin
              if (byte_idx == 2'd0) msb_r <= drd_lcdData;
              if (byte_idx == 2'd1) lsb_r <= drd_lcdData;
              if (byte_idx != 2'd3) byte_idx <= byte_idx + 2'd1;
            end
            if (done_rise) state <= COMPLETE;
            else to_cnt <= to_cnt + 20'd1;
          end
          COMPLETE: begin
            // A read that ends short of two bytes counts as a NACK.
            if (nack_seen || (rw && byte_idx != 2'd2)) begin
              nack_err  <= 1'b1;
              err_count <= err_inc;
            end else if (rw) begin
              temp_data  <= {msb_r, lsb_r};
              temp_valid <= 1'b1;
            end
            poll_cnt <= 24'd0;
            state    <= POLL_WAIT;
          end
          POLL_WAIT: begin
            if (run) begin
              if (poll_pend || poll_now || poll_cnt == POLL_LAST) begin
                poll_pend <= 1'b0;
                poll_cnt  <= 24'd0;
                state     <= RD_ISSUE;
              end else begin
                poll_cnt <= poll_cnt + 24'd1;
              end
            end
          end
          MRESET: begin
            if (mr_cnt) begin
              Master_Enable <= 1'b1;
              poll_cnt      <= 24'd0;
              state         <= POLL_WAIT;
            end else begin
              mr_cnt <= 1'b1;
            end
          end
          default: state <= CFG_ISSUE;
        endcase
      end
    end
  end

endmodule
